// File: rtl/rx78_cart_loader.sv
// RX-78 cartridge loader: streams an HPS file download into the 32 KiB cartridge
// BRAM window, pads the unused tail with FILL_BYTE, then reports size and mirror mask.
module rx78_cart_loader #(
   parameter logic [7:0]  CART_INDEX = 8'd1,
   parameter int unsigned ADDR_W     = 15,
   parameter logic [7:0]  FILL_BYTE  = 8'hFF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ioctl_download,
   input  logic [7:0]        ioctl_index,
   input  logic              ioctl_wr,
   input  logic [24:0]       ioctl_addr,
   input  logic [7:0]        ioctl_dout,
   output logic              cart_we,
   output logic [ADDR_W-1:0] cart_addr,
   output logic [7:0]        cart_din,
   output logic              cart_valid,
   output logic [ADDR_W:0]   cart_size,
   output logic [ADDR_W-1:0] cart_mask,
   output logic              overflow,
   output logic              hold_reset
);

   localparam int unsigned SZ_W = ADDR_W + 1;
   // One past the last window address; also the saturated size value.
   localparam logic [SZ_W-1:0] WIN = SZ_W'(1) << ADDR_W;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] LOAD = 2'd1;
   localparam logic [1:0] PAD  = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [SZ_W-1:0]   size_q, size_d;
   logic [SZ_W-1:0]   pad_q, pad_d;
   logic              we_d;
   logic [ADDR_W-1:0] addr_d;
   logic [7:0]        din_d;
   logic              valid_d;
   logic [SZ_W-1:0]   size_out_d;
   logic [ADDR_W-1:0] mask_d;
   logic              ovf_d;
   logic              hold_d;
   logic              do_load;

   logic              start_c;
   logic              in_win_c;
   logic [SZ_W-1:0]   addr_p1_c;

   assign start_c   = ioctl_download && (ioctl_index == CART_INDEX);
   assign in_win_c  = (ioctl_addr[24:ADDR_W] == '0);
   assign addr_p1_c = SZ_W'(ioctl_addr[ADDR_W-1:0]) + SZ_W'(1);

   // Mirror mask: smear the highest set bit of (size-1) downward, giving 2^k-1 >= size-1.
   function automatic logic [ADDR_W-1:0] mask_of(input logic [SZ_W-1:0] sz);
      logic [ADDR_W-1:0] m;
      m = (sz == '0) ? '0 : ADDR_W'(sz - SZ_W'(1));
      for (int i = 0; i < int'(ADDR_W); i++) begin
         m = m | (m >> 1);
      end
      return m;
   endfunction

   // Next-state and next-output logic.
   always_comb begin
      state_d    = state_q;
      size_d     = size_q;
      pad_d      = pad_q;
      we_d       = 1'b0;
      addr_d     = cart_addr;
      din_d      = cart_din;
      valid_d    = cart_valid;
      size_out_d = cart_size;
      mask_d     = cart_mask;
      ovf_d      = overflow;
      do_load    = 1'b0;

      case (state_q)
         IDLE, DONE: begin
            if (start_c) begin
               state_d    = LOAD;
               valid_d    = 1'b0;
               size_out_d = '0;
               mask_d     = '0;
               ovf_d      = 1'b0;
               size_d     = '0;
               do_load    = 1'b1;
            end
         end
         LOAD: begin
            do_load = 1'b1;
            if (!ioctl_download) begin
               state_d = PAD;
            end
         end
         PAD: begin
            // pad_q reaching WIN means the last window byte was written last cycle.
            if (pad_q == WIN) begin
               state_d    = DONE;
               valid_d    = 1'b1;
               size_out_d = size_q;
               mask_d     = mask_of(size_q);
            end else begin
               we_d   = 1'b1;
               addr_d = pad_q[ADDR_W-1:0];
               din_d  = FILL_BYTE;
               pad_d  = pad_q + SZ_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Download byte: in-window bytes are written and extend size, others flag overflow.
      if (do_load && ioctl_wr) begin
         if (in_win_c) begin
            we_d   = 1'b1;
            addr_d = ioctl_addr[ADDR_W-1:0];
            din_d  = ioctl_dout;
            if (addr_p1_c > size_d) begin
               size_d = addr_p1_c;
            end
         end else begin
            ovf_d  = 1'b1;
            size_d = WIN;
         end
      end

      // Padding resumes right after the highest loaded byte.
      if (state_q == LOAD) begin
         pad_d = size_d;
      end

      hold_d = (state_d == LOAD) || (state_d == PAD);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         size_q     <= '0;
         pad_q      <= '0;
         cart_we    <= 1'b0;
         cart_addr  <= '0;
         cart_din   <= '0;
         cart_valid <= 1'b0;
         cart_size  <= '0;
         cart_mask  <= '0;
         overflow   <= 1'b0;
         hold_reset <= 1'b0;
      end else begin
         state_q    <= state_d;
         size_q     <= size_d;
         pad_q      <= pad_d;
         cart_we    <= we_d;
         cart_addr  <= addr_d;
         cart_din   <= din_d;
         cart_valid <= valid_d;
         cart_size  <= size_out_d;
         cart_mask  <= mask_d;
         overflow   <= ovf_d;
         hold_reset <= hold_d;
      end
   end

endmodule

// File: tb/tb_rx78_cart_loader.sv
// Bench for rx78_cart_loader: stimulus queues expected BRAM writes, a negedge monitor checks them.
module tb_rx78_cart_loader;

   localparam int unsigned ADDR_W = 15;
   localparam int WIN  = 1 << ADDR_W;
   localparam int HEAD = 16;

   logic              clk = 1'b0;
   logic              reset;
   logic              ioctl_download;
   logic [7:0]        ioctl_index;
   logic              ioctl_wr;
   logic [24:0]       ioctl_addr;
   logic [7:0]        ioctl_dout;
   logic              cart_we;
   logic [ADDR_W-1:0] cart_addr;
   logic [7:0]        cart_din;
   logic              cart_valid;
   logic [ADDR_W:0]   cart_size;
   logic [ADDR_W-1:0] cart_mask;
   logic              overflow;
   logic              hold_reset;

   rx78_cart_loader dut (
      .clk            (clk),
      .reset          (reset),
      .ioctl_download (ioctl_download),
      .ioctl_index    (ioctl_index),
      .ioctl_wr       (ioctl_wr),
      .ioctl_addr     (ioctl_addr),
      .ioctl_dout     (ioctl_dout),
      .cart_we        (cart_we),
      .cart_addr      (cart_addr),
      .cart_din       (cart_din),
      .cart_valid     (cart_valid),
      .cart_size      (cart_size),
      .cart_mask      (cart_mask),
      .overflow       (overflow),
      .hold_reset     (hold_reset)
   );

   always #5 clk = ~clk;

   // Posedge count; an output registered at posedge k is observed with pcnt == k.
   int pcnt = 0;
   always @(posedge clk) pcnt <= pcnt + 1;

   typedef struct {
      int                tag;
      logic [ADDR_W-1:0] addr;
      logic [7:0]        din;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   total = 0;
   int   bad   = 0;
   int   fp;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, pcnt);
      end
   endtask

   function automatic logic [7:0] pat(input int a);
      case (a)
         0:       return 8'hA5;
         1:       return 8'h5A;
         2:       return 8'hC3;
         default: return 8'(a * 7 + 1);
      endcase
   endfunction

   // Monitor: every BRAM write must match the head of the expected queue, at its cycle.
   always @(negedge clk) begin
      if (cart_we === 1'b1) begin
         total++;
         if (q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_write: got addr=%0h din=%0h at cycle %0d, expected none",
                     cart_addr, cart_din, pcnt);
         end else begin
            mon_e = q.pop_front();
            if (mon_e.tag != pcnt || mon_e.addr !== cart_addr || mon_e.din !== cart_din) begin
               bad++;
               $display("FAIL bram_write: got addr=%0h din=%0h cycle=%0d expected addr=%0h din=%0h cycle=%0d",
                        cart_addr, cart_din, pcnt, mon_e.addr, mon_e.din, mon_e.tag);
            end
         end
      end
   end

   // Stream a file of n bytes (head and tail HEAD bytes only), optionally ending with
   // the last strobe on the falling edge of ioctl_download; queues load and pad writes.
   task automatic load_file(input logic [7:0] idx, input int n, input bit fall_last,
                            output int fall_p);
      bit match;
      int sz;
      match  = (idx == 8'd1);
      sz     = (n > WIN) ? WIN : n;
      fall_p = 0;
      ioctl_index    = idx;
      ioctl_download = 1'b1;
      ioctl_wr       = 1'b0;
      step();
      chk("hold_reset_at_start", 32'(hold_reset), 32'(match));
      if (match) chk("valid_cleared_at_start", 32'(cart_valid), 32'd0);
      for (int a = 0; a < n; a++) begin
         if (a < HEAD || a >= n - HEAD) begin
            ioctl_wr   = 1'b1;
            ioctl_addr = 25'(a);
            ioctl_dout = pat(a);
            if (fall_last && a == n - 1) begin
               ioctl_download = 1'b0;
               fall_p = pcnt;
            end
            if (match && a < WIN) q.push_back('{tag: pcnt + 1, addr: ADDR_W'(a), din: pat(a)});
            step();
         end
      end
      ioctl_wr = 1'b0;
      if (!fall_last) begin
         ioctl_download = 1'b0;
         fall_p = pcnt;
         step();
      end
      if (match) begin
         for (int s = sz; s < WIN; s++) begin
            q.push_back('{tag: fall_p + 2 + (s - sz), addr: ADDR_W'(s), din: 8'hFF});
         end
      end
   endtask

   task automatic wait_done(input int exp_cyc);
      int n;
      n = 0;
      while (cart_valid !== 1'b1 && n < 40000) begin
         step();
         n++;
      end
      if (cart_valid !== 1'b1) begin
         total++;
         bad++;
         $display("FAIL done_timeout: got cart_valid=%b expected 1 by cycle %0d", cart_valid, exp_cyc);
      end else begin
         chk("done_cycle", 32'(pcnt), 32'(exp_cyc));
      end
      chk("queue_drained", 32'(q.size()), 32'd0);
      chk("hold_reset_in_done", 32'(hold_reset), 32'd0);
   endtask

   task automatic check_reset_vals();
      chk("rst_cart_we",    32'(cart_we),    32'd0);
      chk("rst_cart_addr",  32'(cart_addr),  32'd0);
      chk("rst_cart_din",   32'(cart_din),   32'd0);
      chk("rst_cart_valid", 32'(cart_valid), 32'd0);
      chk("rst_cart_size",  32'(cart_size),  32'd0);
      chk("rst_cart_mask",  32'(cart_mask),  32'd0);
      chk("rst_overflow",   32'(overflow),   32'd0);
      chk("rst_hold_reset", 32'(hold_reset), 32'd0);
   endtask

   initial begin
      reset          = 1'b1;
      ioctl_download = 1'b0;
      ioctl_index    = 8'd0;
      ioctl_wr       = 1'b0;
      ioctl_addr     = '0;
      ioctl_dout     = '0;
      repeat (3) step();
      check_reset_vals();
      reset = 1'b0;
      step();

      // 3-byte file A5,5A,C3 with the last strobe on the falling edge.
      load_file(8'd1, 3, 1'b1, fp);
      wait_done(fp + 2 + WIN - 3);
      chk("small_size",     32'(cart_size), 32'd3);
      chk("small_mask",     32'(cart_mask), 32'h3);
      chk("small_overflow", 32'(overflow),  32'd0);

      // Non-matching index: nothing written, outputs untouched.
      load_file(8'd0, 4, 1'b0, fp);
      step();
      chk("idx0_hold",  32'(hold_reset), 32'd0);
      chk("idx0_valid", 32'(cart_valid), 32'd1);
      chk("idx0_size",  32'(cart_size),  32'd3);
      chk("idx0_mask",  32'(cart_mask),  32'h3);

      // Image filling the whole window: no padding.
      load_file(8'd1, WIN, 1'b0, fp);
      wait_done(fp + 2);
      chk("full_size",     32'(cart_size), 32'h8000);
      chk("full_mask",     32'(cart_mask), 32'h7FFF);
      chk("full_overflow", 32'(overflow),  32'd0);

      // Two bytes past the window.
      load_file(8'd1, WIN + 2, 1'b0, fp);
      wait_done(fp + 2);
      chk("ovf_size",     32'(cart_size), 32'h8000);
      chk("ovf_mask",     32'(cart_mask), 32'h7FFF);
      chk("ovf_overflow", 32'(overflow),  32'd1);

      // Reset while padding.
      load_file(8'd1, 3, 1'b0, fp);
      chk("overflow_cleared_on_load", 32'(overflow), 32'd0);
      repeat (50) step();
      chk("hold_in_pad",  32'(hold_reset), 32'd1);
      chk("valid_in_pad", 32'(cart_valid), 32'd0);
      reset = 1'b1;
      step();
      q.delete();
      check_reset_vals();
      reset = 1'b0;
      step();

      // 8193-byte image after the abort.
      load_file(8'd1, 8193, 1'b0, fp);
      wait_done(fp + 2 + WIN - 8193);
      chk("b8193_size",     32'(cart_size), 32'd8193);
      chk("b8193_mask",     32'(cart_mask), 32'h3FFF);
      chk("b8193_overflow", 32'(overflow),  32'd0);

      repeat (3) step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rx78_cart_loader.md
RX78_CART_LOADER -- requirements
Module: rx78_cart_loader

Interface
REQ-001 SHALL have parameter CART_INDEX, default 8'd1, the ioctl_index value that selects a cartridge download.
REQ-002 SHALL have parameter ADDR_W, default 15, the cartridge window address width (32 KiB window).
REQ-003 SHALL have parameter FILL_BYTE, default 8'hFF, the value written to unloaded window bytes.
REQ-004 SHALL have port clk, input, 1, the single clock (clk_sys), used for all logic.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port ioctl_download, input, 1, high while the HPS streams a file.
REQ-007 SHALL have port ioctl_index, input, 8, the file slot index.
REQ-008 SHALL have port ioctl_wr, input, 1, a one-cycle byte strobe.
REQ-009 SHALL have port ioctl_addr, input, 25, the byte offset in the file.
REQ-010 SHALL have port ioctl_dout, input, 8, the byte data.
REQ-011 SHALL have port cart_we, output, 1, the cartridge BRAM write enable.
REQ-012 SHALL have port cart_addr, output, ADDR_W, the BRAM write address.
REQ-013 SHALL have port cart_din, output, 8, the BRAM write data.
REQ-014 SHALL have port cart_valid, output, 1, high when the image is complete and padded.
REQ-015 SHALL have port cart_size, output, ADDR_W+1, the loaded byte count, saturated at 2^ADDR_W.
REQ-016 SHALL have port cart_mask, output, ADDR_W, the address-mirror mask: next power of two at or above cart_size, minus 1.
REQ-017 SHALL have port overflow, output, 1, sticky; set if the file exceeded the window.
REQ-018 SHALL have port hold_reset, output, 1, high while in LOAD or PAD; the system is held in reset.

Function
REQ-019 SHALL implement states IDLE, LOAD, PAD, DONE.
REQ-020 SHALL have IDLE->LOAD on the cycle ioctl_download=1 and ioctl_index==CART_INDEX; on entry cart_valid=0, size=0, overflow=0.
REQ-021 SHALL, in LOAD, for each ioctl_wr with ioctl_addr < 2^ADDR_W, assert cart_we exactly one cycle later with cart_addr=ioctl_addr[ADDR_W-1:0] and cart_din=ioctl_dout (1-cycle registered latency).
REQ-022 SHALL, in LOAD, track size as max(size, ioctl_addr+1), saturating at 2^ADDR_W.
REQ-023 SHALL, for ioctl_wr with ioctl_addr >= 2^ADDR_W, produce no write and set overflow=1.
REQ-024 SHALL have LOAD->PAD when ioctl_download falls; a write strobe on that same cycle is still committed.
REQ-025 SHALL, in PAD, write FILL_BYTE to one address per cycle, from size up to 2^ADDR_W-1, with cart_we held high.
REQ-026 SHALL skip PAD writes when size == 2^ADDR_W and go directly to DONE the next cycle.
REQ-027 SHALL, in PAD, ignore ioctl_wr.
REQ-028 SHALL have PAD->DONE after the write to address 2^ADDR_W-1; on entering DONE, cart_valid=1 and cart_size/cart_mask are updated.
REQ-029 SHALL give cart_mask=0 when size is 0 or 1; size 8192 -> 0x1FFF; size 8193 -> 0x3FFF.
REQ-030 SHALL have DONE->LOAD on a new matching download, which clears cart_valid the same cycle.
REQ-031 SHALL ignore downloads with a non-matching index in all states; no writes occur and outputs are unchanged.
REQ-032 SHALL have hold_reset = (state==LOAD || state==PAD), registered.
REQ-033 SHALL ensure cart_we is never high in IDLE or DONE.

Reset
REQ-034 SHALL, on reset, go to IDLE with cart_we=0, cart_addr=0, cart_din=0, cart_valid=0, cart_size=0, cart_mask=0, overflow=0, hold_reset=0.
REQ-035 SHALL, on reset during LOAD or PAD, abort; the next matching download restarts from LOAD with size=0.

Verification
REQ-036 SHALL cover: 3-byte file (A5,5A,C3) at index 1 -> writes at 0,1,2 one cycle after each strobe; then PAD writes FF at 3..0x7FFF; DONE with cart_valid=1, cart_size=3, cart_mask=3.
REQ-037 SHALL cover: full 32768-byte file -> no PAD writes; DONE one cycle after download falls; cart_size=0x8000, cart_mask=0x7FFF.
REQ-038 SHALL cover: 32770-byte file -> last two bytes not written; overflow=1; cart_size=0x8000.
REQ-039 SHALL cover: a download at index 0 -> cart_we stays 0 and hold_reset stays 0.
REQ-040 SHALL cover: reset asserted mid-PAD -> all outputs at reset values the next cycle; a following 8193-byte load -> cart_mask=0x3FFF.
REQ-041 SHALL cover: ioctl_wr coincident with the falling edge of ioctl_download -> the byte is written and counted in cart_size.
